if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/rv32i_types.sv | 27 ++
 rtl/if_stage_reg.sv | 22 ++
 rtl/if_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I fetch types, constants and helpers
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  localparam rv32i_word PC_RESET  = 32'h0000_0060;
  localparam rv32i_word NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    IDLE,
    DROP
  } fetch_state_t;

  // One fetched instruction with its PC; used for both the decode-facing
  // output register and the skid buffer.
  typedef struct packed {
    logic      valid;
    rv32i_word pc;
    rv32i_word instruction;
  } fetch_slot_t;

  function automatic rv32i_word next_pc(input rv32i_word pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_reg.sv
// rtl/if_stage_reg.sv - generic load-enabled register with reset value
module if_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when load is high; reset forces the configured value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with skid buffer and redirect handling
module if_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  output logic        inst_read,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction
);

  fetch_state_t state_q, state_d;
  rv32i_word    req_addr, addr_d;
  logic         addr_load;
  rv32i_word    target_q, target_d;
  fetch_slot_t  skid_q, skid_d;
  fetch_slot_t  id_q, id_d;

  // Address of the request currently presented to instruction memory.
  if_stage_reg #(
    .WIDTH      (32),
    .RESET_VALUE(PC_RESET)
  ) u_req_addr (
    .clk (clk),
    .rst (rst),
    .load(addr_load),
    .d   (addr_d),
    .q   (req_addr)
  );

  assign inst_addr      = req_addr;
  assign inst_read      = (state_q != IDLE);
  assign id_valid       = id_q.valid;
  assign id_pc          = id_q.pc;
  assign id_instruction = id_q.instruction;

  // State, redirect target, skid buffer and decode-facing bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      target_q <= '0;
      skid_q   <= '0;
      id_q     <= '{valid: 1'b0, pc: '0, instruction: NOP_INSTR};
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      skid_q   <= skid_d;
      id_q     <= id_d;
    end
  end

  // Next-state, fetch address and output-register update rules.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    skid_d    = skid_q;
    id_d      = id_q;
    addr_load = 1'b0;
    addr_d    = req_addr;

    // Redirect flushes everything buffered; otherwise an unstalled decode
    // sees a bubble unless an instruction is delivered below.
    if (redirect) begin
      id_d.valid   = 1'b0;
      skid_d.valid = 1'b0;
    end else if (!stall) begin
      id_d.valid = 1'b0;
    end

    case (state_q)
      REQ: begin
        if (inst_resp) begin
          addr_load = 1'b1;
          if (redirect) begin
            addr_d = redirect_pc;
          end else begin
            addr_d = next_pc(req_addr);
            if (!stall || !id_q.valid) begin
              id_d = '{valid: 1'b1, pc: req_addr, instruction: inst_rdata};
            end else begin
              skid_d  = '{valid: 1'b1, pc: req_addr, instruction: inst_rdata};
              state_d = IDLE;
            end
          end
        end else if (redirect) begin
          // Keep the memory address stable until the in-flight response lands.
          target_d = redirect_pc;
          state_d  = DROP;
        end
      end

      IDLE: begin
        if (redirect) begin
          addr_load = 1'b1;
          addr_d    = redirect_pc;
          state_d   = REQ;
        end else if (!stall) begin
          id_d         = '{valid: 1'b1, pc: skid_q.pc, instruction: skid_q.instruction};
          skid_d.valid = 1'b0;
          state_d      = REQ;
        end
      end

      DROP: begin
        if (redirect) begin
          target_d = redirect_pc;
        end
        if (inst_resp) begin
          addr_load = 1'b1;
          addr_d    = redirect ? redirect_pc : target_q;
          state_d   = REQ;
        end
      end

      default: begin
        state_d = REQ;
      end
    endcase
  end

endmodule
